// File: rtl/boot_loader_dma.sv
// boot_loader_dma: UART boot loader that handshakes with a host, receives a sized program
// as instruction words, acknowledges it, then streams further bytes out as data words.
//
// Ports:
//   clock          in   1            rising-edge clock
//   reset          in   1            synchronous, active-low
//   rx_ready       in   1            one-cycle pulse, rdata valid
//   rdata          in   8            received UART byte
//   tx_busy        in   1            UART sender busy
//   tx_start       out  1            one-cycle send request
//   sdata          out  8            byte to send, valid with tx_start
//   instr_ready    out  1            one-cycle pulse, data holds an instruction word
//   instr_addr     out  ADDR_W       word index of the instruction on data
//   mem_ready      out  1            one-cycle pulse, data holds a data word
//   data           out  8*WORD_BYTES assembled word
//   program_loaded out  1            high in RUN
//   status         out  16           {state[2:0], err, bytes_received[11:0]}
//
// Optional feature: define BOOT_LOADER_DMA_CHECKSUM_EN to expect a modulo-256 checksum
// byte after the program and answer a mismatch with NAK_BYTE.
module boot_loader_dma #(
    parameter int         WORD_BYTES = 4,
    parameter int         ADDR_W     = 16,
    parameter int         INTERVAL   = 100,
    parameter int         TIMEOUT    = 1000000,
    parameter logic [7:0] SYNC_BYTE  = 8'h99,
    parameter logic [7:0] ACK_BYTE   = 8'haa,
    parameter logic [7:0] NAK_BYTE   = 8'h55
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx_ready,
    input  logic [7:0]              rdata,
    input  logic                    tx_busy,
    output logic                    tx_start,
    output logic [7:0]              sdata,
    output logic                    instr_ready,
    output logic [ADDR_W-1:0]       instr_addr,
    output logic                    mem_ready,
    output logic [8*WORD_BYTES-1:0] data,
    output logic                    program_loaded,
    output logic [15:0]             status
);
    typedef enum logic [2:0] {
        S_SYNC = 3'd0,
        S_SIZE = 3'd1,
        S_PROG = 3'd2,
        S_CSUM = 3'd3,
        S_ACK  = 3'd4,
        S_RUN  = 3'd5
    } state_t;

    state_t                    state;
    logic [8:0]                icnt;
    logic [31:0]               idle;
    logic [31:0]               size;
    logic [31:0]               bytes_rx;
    logic [1:0]                size_cnt;
    logic [3:0]                kb;
    logic [ADDR_W-1:0]         word_idx;
    logic [8*WORD_BYTES-1:0]   acc;
    logic [8*WORD_BYTES-1:0]   nxt;
    logic [31:0]               size_nxt;
    logic                      err;
    logic                      timed;
    logic                      timeout;
    logic                      nak_fire;
    logic                      last;
    logic                      full;

`ifdef BOOT_LOADER_DMA_CHECKSUM_EN
    logic [7:0] csum;
    logic       nak_pend;
    localparam state_t S_DONE = S_CSUM;
    assign timed    = state inside {S_SIZE, S_PROG, S_CSUM};
    // NAK waits in CSUM until the sender is free
    assign nak_fire = (state == S_CSUM) && nak_pend && !tx_busy;
`else
    localparam state_t S_DONE = S_ACK;
    assign timed    = state inside {S_SIZE, S_PROG};
    assign nak_fire = 1'b0;
`endif

    assign size_nxt       = {rdata, size[31:8]};
    assign last           = (bytes_rx + 32'd1) == size;
    assign full           = kb == 4'(WORD_BYTES - 1);
    assign timeout        = timed && !rx_ready && (idle + 32'd1 >= 32'(TIMEOUT));
    assign program_loaded = state == S_RUN;
    assign status         = {state, err, bytes_rx[11:0]};

    // partial word with the incoming byte dropped into lane kb
    always_comb begin
        nxt = acc;
        for (int i = 0; i < WORD_BYTES; i++)
            if (kb == 4'(i)) nxt[8*i +: 8] = rdata;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_SYNC;
            icnt        <= '0;
            idle        <= '0;
            size        <= '0;
            size_cnt    <= '0;
            bytes_rx    <= '0;
            word_idx    <= '0;
            kb          <= '0;
            acc         <= '0;
            err         <= 1'b0;
            tx_start    <= 1'b0;
            sdata       <= '0;
            instr_ready <= 1'b0;
            mem_ready   <= 1'b0;
            data        <= '0;
            instr_addr  <= '0;
`ifdef BOOT_LOADER_DMA_CHECKSUM_EN
            csum        <= '0;
            nak_pend    <= 1'b0;
`endif
        end else begin
            tx_start    <= 1'b0;
            instr_ready <= 1'b0;
            mem_ready   <= 1'b0;
            idle        <= (rx_ready || !timed) ? '0 : idle + 32'd1;
            if (timeout || nak_fire) begin
                state    <= S_SYNC;
                err      <= 1'b1;
                icnt     <= '0;
                idle     <= '0;
                size     <= '0;
                size_cnt <= '0;
                bytes_rx <= '0;
                word_idx <= '0;
                kb       <= '0;
                acc      <= '0;
                tx_start <= nak_fire;
                sdata    <= nak_fire ? NAK_BYTE : sdata;
`ifdef BOOT_LOADER_DMA_CHECKSUM_EN
                csum     <= '0;
                nak_pend <= 1'b0;
`endif
            end else begin
                case (state)
                    S_SYNC: begin
                        if (icnt >= 9'(INTERVAL) && !tx_busy) begin
                            tx_start <= 1'b1;
                            sdata    <= SYNC_BYTE;
                            icnt     <= '0;
                        end else if (icnt < 9'(INTERVAL)) begin
                            icnt <= icnt + 9'd1;
                        end
                        if (rx_ready) state <= S_SIZE;
                    end
                    S_SIZE: begin
                        if (rx_ready) begin
                            size     <= size_nxt;
                            size_cnt <= size_cnt + 2'd1;
                            if (size_cnt == 2'd3) state <= (size_nxt == '0) ? S_DONE : S_PROG;
                        end
                    end
                    S_PROG: begin
                        if (rx_ready) begin
                            bytes_rx <= bytes_rx + 32'd1;
`ifdef BOOT_LOADER_DMA_CHECKSUM_EN
                            csum     <= csum + rdata;
`endif
                            // the final byte flushes a partial word; unfilled lanes stay zero
                            if (full || last) begin
                                data        <= nxt;
                                instr_ready <= 1'b1;
                                instr_addr  <= word_idx;
                                word_idx    <= word_idx + 1'b1;
                                acc         <= '0;
                                kb          <= '0;
                            end else begin
                                acc <= nxt;
                                kb  <= kb + 4'd1;
                            end
                            if (last) state <= S_DONE;
                        end
                    end
`ifdef BOOT_LOADER_DMA_CHECKSUM_EN
                    S_CSUM: begin
                        if (rx_ready && !nak_pend) begin
                            if (rdata == csum) state <= S_ACK;
                            else nak_pend <= 1'b1;
                        end
                    end
`endif
                    S_ACK: begin
                        if (!tx_busy) begin
                            tx_start <= 1'b1;
                            sdata    <= ACK_BYTE;
                            state    <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (rx_ready) begin
                            if (full) begin
                                data      <= nxt;
                                mem_ready <= 1'b1;
                                acc       <= '0;
                                kb        <= '0;
                            end else begin
                                acc <= nxt;
                                kb  <= kb + 4'd1;
                            end
                        end
                    end
                    default: state <= S_SYNC;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_boot_loader_dma.sv
// tb_boot_loader_dma: scoreboard bench for boot_loader_dma; one 4-byte-word instance and
// one 2-byte-word instance, expected pulses queued before stimulus and popped on output.
module tb_boot_loader_dma;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rdata = '0;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  sdata;
    logic        instr_ready;
    logic [15:0] instr_addr;
    logic        mem_ready;
    logic [31:0] data;
    logic        program_loaded;
    logic [15:0] status;

    logic        rx_ready_b = 1'b0;
    logic [7:0]  rdata_b = '0;
    logic        tx_busy_b = 1'b0;
    logic        tx_start_b;
    logic [7:0]  sdata_b;
    logic        instr_ready_b;
    logic [15:0] instr_addr_b;
    logic        mem_ready_b;
    logic [15:0] data_b;
    logic        program_loaded_b;
    logic [15:0] status_b;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int sync_times[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_tx_b[$];
    logic [47:0] exp_instr[$];
    logic [15:0] exp_mem_b[$];

    boot_loader_dma #(.WORD_BYTES(4), .ADDR_W(16), .INTERVAL(4), .TIMEOUT(50)) dut (
        .clock(clock), .reset(reset), .rx_ready(rx_ready), .rdata(rdata), .tx_busy(tx_busy),
        .tx_start(tx_start), .sdata(sdata), .instr_ready(instr_ready), .instr_addr(instr_addr),
        .mem_ready(mem_ready), .data(data), .program_loaded(program_loaded), .status(status)
    );

    boot_loader_dma #(.WORD_BYTES(2), .ADDR_W(16), .INTERVAL(4), .TIMEOUT(50)) dut_b (
        .clock(clock), .reset(reset), .rx_ready(rx_ready_b), .rdata(rdata_b), .tx_busy(tx_busy_b),
        .tx_start(tx_start_b), .sdata(sdata_b), .instr_ready(instr_ready_b), .instr_addr(instr_addr_b),
        .mem_ready(mem_ready_b), .data(data_b), .program_loaded(program_loaded_b), .status(status_b)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_a(input logic [7:0] b);
        rx_ready = 1'b1;
        rdata    = b;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        rx_ready_b = 1'b1;
        rdata_b    = b;
        tick();
        rx_ready_b = 1'b0;
    endtask

    // one discarded byte leaves SYNC, then the little-endian size
    task automatic size_a(input logic [31:0] n);
        send_a(8'h00);
        for (int i = 0; i < 4; i++) send_a(n[8*i +: 8]);
    endtask

    task automatic size_b(input logic [31:0] n);
        send_b(8'h00);
        for (int i = 0; i < 4; i++) send_b(n[8*i +: 8]);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    always @(negedge clock) if (reset) begin
        if (tx_start) begin
            if (sdata == 8'h99) sync_times.push_back(cyc);
            else if (exp_tx.size() == 0) chk("tx_extra", 64'(sdata), 64'h100);
            else chk("tx_byte", 64'(sdata), 64'(exp_tx.pop_front()));
        end
        if (instr_ready) begin
            if (exp_instr.size() == 0) chk("instr_extra", 64'({instr_addr, data}), 64'hffff_ffff_ffff_ffff);
            else chk("instr_word", 64'({instr_addr, data}), 64'(exp_instr.pop_front()));
        end
        if (instr_ready || mem_ready) chk("excl", 64'(instr_ready & mem_ready), 64'd0);
        if (tx_start_b && sdata_b != 8'h99) begin
            if (exp_tx_b.size() == 0) chk("tx_b_extra", 64'(sdata_b), 64'h100);
            else chk("tx_b_byte", 64'(sdata_b), 64'(exp_tx_b.pop_front()));
        end
        if (instr_ready_b) chk("instr_b_extra", 64'(instr_addr_b), 64'hffff);
        if (mem_ready_b) begin
            if (exp_mem_b.size() == 0) chk("mem_b_extra", 64'(data_b), 64'h1_0000);
            else chk("mem_b_word", 64'(data_b), 64'(exp_mem_b.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // reset state
        ticks(2);
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_pulses", 64'({tx_start, instr_ready, mem_ready, program_loaded}), 64'd0);
        chk("rst_data", 64'({data, instr_addr, sdata}), 64'd0);
        reset = 1'b1;

        // SYNC every INTERVAL+1 cycles, none while busy
        ticks(25);
        chk("sync_count", 64'(sync_times.size() >= 4), 64'd1);
        for (int i = 1; i < sync_times.size(); i++)
            chk("sync_gap", 64'(sync_times[i] - sync_times[i-1]), 64'd5);
        tx_busy = 1'b1;
        tick();
        sync_times.delete();
        ticks(20);
        chk("sync_busy", 64'(sync_times.size()), 64'd0);
        tx_busy = 1'b0;

        // size 8, two full words, then ACK
        send_a(8'h00);
        chk("state_size", 64'(status[15:13]), 64'd1);
        for (int i = 0; i < 4; i++) send_a(i == 0 ? 8'h08 : 8'h00);
        chk("state_prog", 64'(status[15:13]), 64'd2);
        exp_instr.push_back({16'd0, 32'h04030201});
        exp_instr.push_back({16'd1, 32'h08070605});
        for (int i = 1; i <= 8; i++) begin
            send_a(8'(i));
            if (i == 4) chk("instr_lat", 64'(instr_ready), 64'd1);
        end
        chk("bytes_rx", 64'(status[11:0]), 64'd8);
`ifdef BOOT_LOADER_DMA_CHECKSUM_EN
        send_a(8'h24);
`endif
        exp_tx.push_back(8'haa);
        ticks(3);
        chk("loaded", 64'(program_loaded), 64'd1);
        chk("state_run", 64'(status[15:13]), 64'd5);

        // size 6, partial final word zero-filled
        pulse_reset();
        exp_instr.push_back({16'd0, 32'h14131211});
        exp_instr.push_back({16'd1, 32'h00001615});
        size_a(32'd6);
        for (int i = 0; i < 6; i++) send_a(8'h11 + 8'(i));
`ifdef BOOT_LOADER_DMA_CHECKSUM_EN
        send_a(8'h75);
`endif
        exp_tx.push_back(8'haa);
        ticks(3);
        chk("loaded6", 64'(program_loaded), 64'd1);

        // stall mid-PROG for TIMEOUT cycles
        pulse_reset();
        size_a(32'd8);
        for (int i = 1; i <= 3; i++) send_a(8'(i));
        ticks(49);
        chk("to_before", 64'(status[15:13]), 64'd2);
        tick();
        chk("to_state", 64'(status[15:13]), 64'd0);
        chk("to_err", 64'(status[12]), 64'd1);
        chk("to_bytes", 64'(status[11:0]), 64'd0);
        exp_instr.push_back({16'd0, 32'h24232221});
        size_a(32'd4);
        for (int i = 0; i < 4; i++) send_a(8'h21 + 8'(i));
`ifdef BOOT_LOADER_DMA_CHECKSUM_EN
        send_a(8'h8a);
`endif
        exp_tx.push_back(8'haa);
        ticks(3);
        chk("to_reload", 64'(program_loaded), 64'd1);

        // 2-byte words in RUN: one word, trailing byte held
        size_b(32'd0);
`ifdef BOOT_LOADER_DMA_CHECKSUM_EN
        send_b(8'h00);
`endif
        exp_tx_b.push_back(8'haa);
        ticks(3);
        chk("b_loaded", 64'(program_loaded_b), 64'd1);
        chk("b_state", 64'(status_b[15:13]), 64'd5);
        exp_mem_b.push_back(16'hbbaa);
        send_b(8'haa);
        send_b(8'hbb);
        chk("mem_lat", 64'(mem_ready_b), 64'd1);
        send_b(8'hcc);
        ticks(3);
        chk("b_held", 64'(data_b), 64'hbbaa);

        // reset wins over a word-completing byte
        rx_ready_b = 1'b1;
        rdata_b    = 8'hdd;
        reset      = 1'b0;
        tick();
        rx_ready_b = 1'b0;
        chk("ovr_pulse", 64'(mem_ready_b), 64'd0);
        chk("ovr_data", 64'(data_b), 64'd0);
        chk("ovr_loaded", 64'(program_loaded_b), 64'd0);
        reset = 1'b1;
        tick();
        chk("ovr_after", 64'({mem_ready_b, tx_start_b}), 64'd0);

`ifdef BOOT_LOADER_DMA_CHECKSUM_EN
        pulse_reset();
        size_a(32'd2);
        exp_instr.push_back({16'd0, 32'h00000201});
        send_a(8'h01);
        send_a(8'h02);
        exp_tx.push_back(8'h55);
        send_a(8'h04);
        ticks(3);
        chk("nak_state", 64'(status[15:13]), 64'd0);
        chk("nak_err", 64'(status[12]), 64'd1);
        size_a(32'd2);
        exp_instr.push_back({16'd0, 32'h00000201});
        send_a(8'h01);
        send_a(8'h02);
        exp_tx.push_back(8'haa);
        send_a(8'h03);
        ticks(3);
        chk("csum_ok", 64'(program_loaded), 64'd1);
`endif

        ticks(2);
        chk("q_tx", 64'(exp_tx.size()), 64'd0);
        chk("q_tx_b", 64'(exp_tx_b.size()), 64'd0);
        chk("q_instr", 64'(exp_instr.size()), 64'd0);
        chk("q_mem_b", 64'(exp_mem_b.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
